inst_mem: RTL and testbench

Instruction memory responder at the far end of the fetch interface. Accepts the fetch unit's address and enable and returns the instruction word in the same cycle, as the single-cycle core requires. After reset, it fills itself with NOPs in a hardware sweep. It then accepts program words from a loader over a valid/ready write port.

---
 rtl/inst_mem_pkg.sv | 23 ++
 rtl/inst_ram.sv | 27 ++
 rtl/inst_mem.sv | 115 +++++++++++
 tb/tb_inst_mem.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: word width, NOP encoding,
// default depth, FSM state encoding and the byte-address range helper.
package inst_mem_pkg;

    localparam int XLEN           = 32;
    localparam int PC_WIDTH       = 32;
    localparam int INST_MEM_DEPTH = 1024;

    localparam logic [XLEN-1:0] INST_NOP = 32'h00000013;

    typedef enum logic {
        IMEM_INIT  = 1'b0,
        IMEM_READY = 1'b1
    } imem_state_t;

    // Depth is a power of two, so "below DEPTH*4" means every bit above the
    // byte offset and word index is zero; no wrap-around aliasing.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                           input int addr_bits);
        return (addr >> (addr_bits + 2)) == '0;
    endfunction

endpackage

// File: rtl/inst_ram.sv
// DEPTH x 32 storage with one synchronous write port and one asynchronous
// read port, kept separate so it can be swapped for FPGA distributed RAM.
module inst_ram
    import inst_mem_pkg::*;
#(
    parameter int DEPTH     = INST_MEM_DEPTH,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [XLEN-1:0]      rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem.sv
// Instruction memory responder: NOP sweep after reset, combinational fetch,
// valid/ready loader port. Define INST_MEM_FAULT_EN for the sticky fetch fault.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int   DEPTH     = INST_MEM_DEPTH,
    localparam int  ADDR_BITS = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_ce_i,
    input  logic [XLEN-1:0] inst_addr_i,
    output logic [XLEN-1:0] inst_o,
    input  logic            prog_valid_i,
    output logic            prog_ready_o,
    input  logic [XLEN-1:0] prog_addr_i,
    input  logic [XLEN-1:0] prog_data_i,
    output logic            init_done_o
`ifdef INST_MEM_FAULT_EN
    ,
    output logic            fetch_fault_o,
    output logic [XLEN-1:0] fault_addr_o
`endif
);

    imem_state_t          state;
    imem_state_t          state_nxt;
    logic [ADDR_BITS-1:0] clr_idx;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [XLEN-1:0]      ram_wdata;
    logic [XLEN-1:0]      ram_rdata;
    logic                 fetch_in_range;
    logic                 prog_in_range;
    logic                 unused_addr_bits;

    assign fetch_in_range   = addr_in_range(inst_addr_i, ADDR_BITS);
    assign prog_in_range    = addr_in_range(prog_addr_i, ADDR_BITS);
    assign unused_addr_bits = ^{inst_addr_i[1:0], prog_addr_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IMEM_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (state == IMEM_INIT) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IMEM_INIT && clr_idx == ADDR_BITS'(DEPTH - 1)) begin
            state_nxt = IMEM_READY;
        end
    end

    // The sweep owns the write port in INIT; the loader owns it in READY, and
    // out-of-range loader writes complete the handshake but never hit the array.
    always_comb begin
        init_done_o  = (state == IMEM_READY);
        prog_ready_o = (state == IMEM_READY);
        ram_we       = 1'b0;
        ram_waddr    = prog_addr_i[ADDR_BITS+1:2];
        ram_wdata    = prog_data_i;
        if (state == IMEM_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = INST_NOP;
        end else if (prog_valid_i && prog_in_range) begin
            ram_we = 1'b1;
        end
        inst_o = INST_NOP;
        if (inst_ce_i && state == IMEM_READY && fetch_in_range) begin
            inst_o = ram_rdata;
        end
    end

    inst_ram #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_inst_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (inst_addr_i[ADDR_BITS+1:2]),
        .rdata (ram_rdata)
    );

`ifdef INST_MEM_FAULT_EN
    logic fault_now;

    assign fault_now = (state == IMEM_READY) && inst_ce_i &&
                       ((inst_addr_i[1:0] != 2'b00) || !fetch_in_range);

    // Only the first fault is captured; the record is held until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_fault_o <= 1'b0;
            fault_addr_o  <= '0;
        end else if (fault_now && !fetch_fault_o) begin
            fetch_fault_o <= 1'b1;
            fault_addr_o  <= inst_addr_i;
        end
    end
`endif

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem at DEPTH=16; fault checks are compiled in
// when INST_MEM_FAULT_EN is defined.
module tb_inst_mem;

   localparam int DEPTH = 16;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam int WAIT_LIMIT = 4 * DEPTH;
   localparam int RUN_LIMIT  = 400;

   localparam int K_INST  = 0;
   localparam int K_DONE  = 1;
   localparam int K_READY = 2;
   localparam int K_FAULT = 3;
   localparam int K_FADDR = 4;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_ce_i = 1'b0;
   logic [31:0] inst_addr_i = '0;
   logic [31:0] inst_o;
   logic        prog_valid_i = 1'b0;
   logic        prog_ready_o;
   logic [31:0] prog_addr_i = '0;
   logic [31:0] prog_data_i = '0;
   logic        init_done_o;
`ifdef INST_MEM_FAULT_EN
   logic        fetch_fault_o;
   logic [31:0] fault_addr_o;
`endif

   exp_t scoreboard[$];
   int   checks = 0;
   int   errors = 0;

   inst_mem #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_ce_i    (inst_ce_i),
      .inst_addr_i  (inst_addr_i),
      .inst_o       (inst_o),
      .prog_valid_i (prog_valid_i),
      .prog_ready_o (prog_ready_o),
      .prog_addr_i  (prog_addr_i),
      .prog_data_i  (prog_data_i),
      .init_done_o  (init_done_o)
`ifdef INST_MEM_FAULT_EN
      ,
      .fetch_fault_o(fetch_fault_o),
      .fault_addr_o (fault_addr_o)
`endif
   );

   always #5 clk = ~clk;

   // Monitor: every expectation queued during the cycle is compared at the
   // falling edge, half a period away from the edge that updates state.
   always @(negedge clk) begin
      while (scoreboard.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e   = scoreboard.pop_front();
         act = 'x;
         case (e.kind)
            K_INST:  act = inst_o;
            K_DONE:  act = {31'b0, init_done_o};
            K_READY: act = {31'b0, prog_ready_o};
`ifdef INST_MEM_FAULT_EN
            K_FAULT: act = {31'b0, fetch_fault_o};
            K_FADDR: act = fault_addr_o;
`endif
            default: act = 'x;
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
         end
      end
   end

   // Watchdog: the whole run must finish within a bounded number of cycles.
   initial begin
      repeat (RUN_LIMIT) @(posedge clk);
      errors++;
      $display("[TB] FAIL watchdog: run exceeded %0d cycles", RUN_LIMIT);
      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic waitForDone(input string tag);
      int n;
      n = 0;
      while (init_done_o !== 1'b1 && n < WAIT_LIMIT) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (init_done_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s: init_done_o not seen within %0d cycles", tag, WAIT_LIMIT);
      end
   endtask

   task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      scoreboard.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fetch(input logic ce, input logic [31:0] addr);
      inst_ce_i   = ce;
      inst_addr_i = addr;
   endtask

   task automatic set_prog(input logic valid, input logic [31:0] addr, input logic [31:0] data);
      prog_valid_i = valid;
      prog_addr_i  = addr;
      prog_data_i  = data;
   endtask

   task automatic expect_fault(input string tag, input logic flag, input logic [31:0] addr);
`ifdef INST_MEM_FAULT_EN
      expect_val({tag, "_flag"}, K_FAULT, {31'b0, flag});
      expect_val({tag, "_addr"}, K_FADDR, addr);
`else
      if (flag === 1'bx && addr === 'x) $display("[TB] fault ports absent");
`endif
   endtask

   // Runs one full sweep from a just-released reset: DEPTH cycles not ready,
   // fetches forced to NOP, then ready.
   task automatic run_sweep(input string tag);
      set_fetch(1'b1, 32'h8);
      for (int i = 0; i < DEPTH; i++) begin
         expect_val({tag, "_done_low"},  K_DONE,  32'd0);
         expect_val({tag, "_ready_low"}, K_READY, 32'd0);
         expect_val({tag, "_fetch_nop"}, K_INST,  NOP);
         step();
      end
      expect_val({tag, "_done_high"},  K_DONE,  32'd1);
      expect_val({tag, "_ready_high"}, K_READY, 32'd1);
   endtask

   initial begin
      step();
      checkOutput("rst_done_direct",  {31'b0, init_done_o},  32'd0);
      checkOutput("rst_ready_direct", {31'b0, prog_ready_o}, 32'd0);
      expect_val("rst_done",  K_DONE,  32'd0);
      expect_val("rst_ready", K_READY, 32'd0);
      expect_fault("rst_fault", 1'b0, 32'h0);
      step();
      rst = 1'b0;
      run_sweep("sweep");
      waitForDone("sweep_wait");

      // Misaligned then out-of-range fetch; only the first is recorded.
      set_fetch(1'b1, 32'h6);
      expect_val("fetch_misaligned", K_INST, NOP);
      step();
      set_fetch(1'b1, 32'h44);
      expect_val("fetch_oob_44", K_INST, NOP);
      step();
      set_fetch(1'b0, 32'h0);
      expect_fault("fault_first", 1'b1, 32'h6);
      step();

      set_prog(1'b1, 32'h8, 32'h00500093);
      expect_val("load_ready", K_READY, 32'd1);
      step();
      set_prog(1'b0, 32'h0, 32'h0);
      set_fetch(1'b1, 32'h8);
      expect_val("fetch_8", K_INST, 32'h00500093);
      step();
      set_fetch(1'b1, 32'hC);
      expect_val("fetch_c", K_INST, NOP);
      step();
      set_fetch(1'b1, 32'hB);
      expect_val("fetch_b_trunc", K_INST, 32'h00500093);
      step();

      set_prog(1'b1, 32'h4, 32'hDEADBEEF);
      set_fetch(1'b1, 32'h4);
      expect_val("hazard_old", K_INST, NOP);
      step();
      set_prog(1'b0, 32'h0, 32'h0);
      expect_val("hazard_new", K_INST, 32'hDEADBEEF);
      step();

      set_prog(1'b1, 32'h3C, 32'h0FF00113);
      step();
      set_prog(1'b0, 32'h0, 32'h0);
      set_fetch(1'b1, 32'h3C);
      expect_val("fetch_last_word", K_INST, 32'h0FF00113);
      step();
      set_fetch(1'b1, 32'h40);
      expect_val("fetch_oob_40", K_INST, NOP);
      step();
      set_prog(1'b1, 32'h40, 32'hBAD0BAD0);
      set_fetch(1'b1, 32'h0);
      expect_val("oob_write_ready", K_READY, 32'd1);
      step();
      set_prog(1'b0, 32'h0, 32'h0);
      expect_val("oob_write_no_alias", K_INST, NOP);
      step();
      set_fetch(1'b0, 32'h8);
      expect_val("ce_low_nop", K_INST, NOP);
      expect_fault("fault_held", 1'b1, 32'h6);
      step();

      // Reset in the middle of a sweep restarts it from index 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         expect_val("partial_done_low", K_DONE, 32'd0);
         step();
      end
      rst = 1'b1;
      expect_val("midsweep_rst_done", K_DONE, 32'd0);
      expect_fault("fault_cleared", 1'b0, 32'h0);
      step();
      rst = 1'b0;
      run_sweep("resweep");
      waitForDone("resweep_wait");
      set_fetch(1'b1, 32'h8);
      expect_val("resweep_cleared_8", K_INST, NOP);
      step();
      step();

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
